alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width (legal range 4..64).
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request present on A, B, control.
REQ-005 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port: A  input  WIDTH  operand A, two's complement.
REQ-007 SHALL have port: B  input  WIDTH  operand B, two's complement.
REQ-008 SHALL have port: control  input  3  opcode: 000 SLT, 001 MUL, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOR, 111 XOR.
REQ-009 SHALL have port: out_valid  output  1  result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port: out  output  WIDTH  registered result.
REQ-012 SHALL have port: overflow  output  1  signed overflow of the completed operation.
REQ-013 SHALL have port: zero  output  1  out == 0.
REQ-014 SHALL have port: negative  output  1  out[WIDTH-1].

Function
REQ-015 SHALL implement FSM states IDLE (no result), BUSY (MUL iterating), DONE (result held, out_valid=1).
REQ-016 SHALL accept a request on a rising edge when in_valid && in_ready; A, B, control captured at that edge.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready=0 in BUSY.
REQ-018 SHALL, for non-MUL ops, enter DONE with registered result so out_valid=1 the cycle after acceptance (latency 1).
REQ-019 SHALL, for MUL, enter BUSY, run iterative shift-add over operand magnitudes for exactly WIDTH cycles, then enter DONE; out_valid=1 WIDTH+1 cycles after acceptance.
REQ-020 SHALL compute MUL as signed product: out = low WIDTH bits; overflow=1 iff full 2*WIDTH-bit signed product not representable in WIDTH signed bits.
REQ-021 SHALL compute ADD/SUB modulo 2^WIDTH; overflow=1 iff operand signs (B inverted for SUB) agree and result sign differs.
REQ-022 SHALL compute SLT as out = 1 if A < B signed else 0; overflow=0.
REQ-023 SHALL set overflow=0 for AND, OR, NOR, XOR.
REQ-024 SHALL derive zero and negative from the registered out, valid whenever out_valid=1.
REQ-025 SHALL hold out, flags, out_valid stable in DONE while out_ready=0 (backpressure, no loss).
REQ-026 SHALL in DONE with out_ready=1 and no new acceptance go to IDLE, out_valid=0 next cycle.
REQ-027 SHALL in DONE with out_ready=1 and in_valid=1 accept back-to-back: non-MUL gives DONE again (one result per cycle); MUL goes to BUSY.
REQ-028 SHALL ignore in_valid in BUSY; in_valid without acceptance has no effect.
REQ-029 SHALL treat MUL with either operand 0 as full WIDTH-cycle operation (fixed latency, no early exit).
REQ-030 SHALL produce for MUL of -2^(WIDTH-1) by -1: out = -2^(WIDTH-1), overflow=1.

Reset
REQ-031 SHALL on reset_n=0 immediately (asynchronously) force state IDLE, out_valid=0, out=0, overflow=0, zero=1, negative=0, iteration counter=0.
REQ-032 SHALL abort any BUSY multiply on reset; no result emitted for it after release.
REQ-033 SHALL have in_ready=1 in the first cycle after reset_n rises.

Verification
REQ-034 SHALL cover: WIDTH=32, ADD A=2147483647 B=1, out_ready=1 -> next cycle out_valid=1, out=0x80000000, overflow=1, negative=1, zero=0.
REQ-035 SHALL cover: SUB A=5 B=5 then XOR A=0xff B=0x83 back-to-back, out_ready=1 -> consecutive cycles out=0 zero=1, then out=0x7c zero=0.
REQ-036 SHALL cover: MUL A=-7 B=6 -> in_ready=0 for 32 cycles, out_valid 33 cycles after acceptance, out=-42, overflow=0, negative=1.
REQ-037 SHALL cover: MUL A=0x00010000 B=0x00010000 -> out=0, zero=1, overflow=1; MUL 0x80000000 by -1 -> out=0x80000000, overflow=1.
REQ-038 SHALL cover: NOR A=0 B=0 with out_ready=0 for 5 cycles -> out=0xffffffff held, in_ready=0, new in_valid ignored; out_ready=1 releases exactly one result.
REQ-039 SHALL cover: reset_n pulsed low mid-MUL (cycle 10) -> outputs at reset values immediately, no out_valid afterwards until a new request; repeat SLT A=-1 B=0 at WIDTH=8 -> out=1.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: one-cycle logic/arith ops, WIDTH-cycle shift-add signed multiply
// Valid/ready handshake on both sides; result and flags held in DONE until consumed.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_SLT = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic                accept;
  logic                last_iter;
  logic [WIDTH-1:0]    sum, diff, alu_res;
  logic                alu_ovf;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [2*WIDTH-1:0]  mcand, acc, acc_next, prod;
  logic [WIDTH-1:0]    mplier;
  logic                prod_neg;
  logic                mul_ovf;
  logic [CW-1:0]       count;

  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      default: alu_res = A ^ B;
    endcase
  end

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
  assign a_mag    = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag    = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign prod     = prod_neg ? (~acc_next + 1'b1) : acc_next;
  // Representable iff the upper WIDTH+1 bits are a pure sign extension.
  assign mul_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

  always_comb begin
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid  = (state == DONE);
    accept     = in_valid && in_ready;
    last_iter  = (count == CW'(WIDTH-1));
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (control == OP_MUL) ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: begin
        if (accept)         state_next = (control == OP_MUL) ? BUSY : DONE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out      <= '0;
      overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      prod_neg <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      if (control == OP_MUL) begin
        mcand    <= {{WIDTH{1'b0}}, a_mag};
        mplier   <= b_mag;
        acc      <= '0;
        prod_neg <= A[WIDTH-1] ^ B[WIDTH-1];
        count    <= '0;
      end else begin
        out      <= alu_res;
        overflow <= alu_ovf;
      end
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count + 1'b1;
      if (last_iter) begin
        out      <= prod[WIDTH-1:0];
        overflow <= mul_ovf;
        count    <= '0;
      end
    end
  end

  assign zero     = (out == '0);
  assign negative = out[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances)
module tb_alu_seq;
  logic        clock;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_in, b_in, out_w;
  logic [2:0]  control;
  logic        ovf_w, zero_w, neg_w;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, out8;
  logic [2:0]  control8;
  logic        ovf8, zero8, neg8;

  int checks = 0;
  int errors = 0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .out(out_w), .overflow(ovf_w), .zero(zero_w), .negative(neg_w)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .control(control8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .overflow(ovf8), .zero(zero8), .negative(neg8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: signed arithmetic on wide integers, overflow as a range test.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0;
    o = 1'b0;
    case (op)
      3'd0: full = (sa < sb) ? 1 : 0;
      3'd1: begin full = sa * sb; o = (full > MAXV) || (full < MINV); end
      3'd2: begin full = sa + sb; o = (full > MAXV) || (full < MINV); end
      3'd3: begin full = sa - sb; o = (full > MAXV) || (full < MINV); end
      3'd4: full = longint'(a & b);
      3'd5: full = longint'(a | b);
      3'd6: full = longint'(~(a | b));
      default: full = longint'(a ^ b);
    endcase
    r = full[31:0];
  endfunction

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic eov);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clock); guard++; end
    in_valid = 1'b1; control = op; a_in = a; b_in = b; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clock); lat++; end
    check({nm, "_lat"}, 64'(lat), (op == 3'd1) ? 64'd33 : 64'd1);
    check({nm, "_out"}, 64'(out_w), 64'(eo));
    check({nm, "_ovf"}, 64'(ovf_w), 64'(eov));
    check({nm, "_zero"}, 64'(zero_w), 64'(eo == 32'd0));
    check({nm, "_neg"}, 64'(neg_w), 64'(eo[31]));
  endtask

  initial begin
    logic [31:0] ra, rb, r_exp;
    logic        o_exp;
    logic [2:0]  rop;
    int          n, guard;

    vecs[0]  = '{"add_max",  3'd2, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{"sub_eq",   3'd3, 32'd5,        32'd5,        32'h00000000, 1'b0};
    vecs[2]  = '{"xor",      3'd7, 32'h000000ff, 32'h00000083, 32'h0000007c, 1'b0};
    vecs[3]  = '{"mul_m7x6", 3'd1, 32'hfffffff9, 32'd6,        32'hffffffd6, 1'b0};
    vecs[4]  = '{"mul_2p32", 3'd1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[5]  = '{"mul_minm1",3'd1, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b1};
    vecs[6]  = '{"nor0",     3'd6, 32'h0,        32'h0,        32'hffffffff, 1'b0};
    vecs[7]  = '{"slt_neg",  3'd0, 32'hffffffff, 32'h0,        32'h00000001, 1'b0};
    vecs[8]  = '{"slt_pos",  3'd0, 32'h0,        32'hffffffff, 32'h00000000, 1'b0};
    vecs[9]  = '{"sub_min",  3'd3, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1};
    vecs[10] = '{"mul_zero", 3'd1, 32'h0,        32'h00012345, 32'h00000000, 1'b0};
    vecs[11] = '{"and",      3'd4, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0};
    vecs[12] = '{"or",       3'd5, 32'hf0f0f0f0, 32'h0000ff00, 32'hf0f0fff0, 1'b0};
    vecs[13] = '{"add_wrap", 3'd2, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; control = 3'd0; a_in = '0; b_in = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; control8 = 3'd0; a8 = '0; b8 = '0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out",   64'(out_w),     64'd0);
    check("rst_zero",  64'(zero_w),    64'd1);
    check("rst_neg",   64'(neg_w),     64'd0);
    check("rst_ovf",   64'(ovf_w),     64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_ovf);

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ra = $urandom_range(0, 511); ra = ra - 32'd256;
        rb = $urandom_range(0, 511); rb = rb - 32'd256;
      end
      model(rop, ra, rb, r_exp, o_exp);
      run_op("rand", rop, ra, rb, r_exp, o_exp);
    end

    // Back-to-back SUB then XOR, one result per cycle.
    @(negedge clock); @(negedge clock);
    in_valid = 1'b1; control = 3'd3; a_in = 32'd5; b_in = 32'd5; out_ready = 1'b1;
    @(negedge clock);
    check("b2b_v1",   64'(out_valid), 64'd1);
    check("b2b_out1", 64'(out_w),     64'd0);
    check("b2b_z1",   64'(zero_w),    64'd1);
    control = 3'd7; a_in = 32'hff; b_in = 32'h83;
    @(negedge clock);
    in_valid = 1'b0;
    check("b2b_v2",   64'(out_valid), 64'd1);
    check("b2b_out2", 64'(out_w),     64'h7c);
    check("b2b_z2",   64'(zero_w),    64'd0);
    @(negedge clock);
    check("b2b_idle", 64'(out_valid), 64'd0);

    // MUL busy window with in_valid held high and a stalled consumer.
    in_valid = 1'b1; control = 3'd1; a_in = 32'hfffffff9; b_in = 32'd6; out_ready = 1'b0;
    @(negedge clock);
    control = 3'd2; a_in = 32'd1; b_in = 32'd1;
    n = 0; guard = 0;
    while (!out_valid && guard < 100) begin
      if (!in_ready) n++;
      @(negedge clock); guard++;
    end
    check("mul_busy_cycles", 64'(n), 64'd32);
    @(negedge clock);
    check("mul_held_out", 64'(out_w), 64'hffffffd6);
    check("mul_held_neg", 64'(neg_w), 64'd1);
    check("mul_held_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("mul_release", 64'(out_valid), 64'd0);

    // NOR held under backpressure; stray requests ignored; one release.
    in_valid = 1'b1; control = 3'd6; a_in = '0; b_in = '0; out_ready = 1'b0;
    @(negedge clock);
    control = 3'd2; a_in = 32'd1; b_in = 32'd1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid && out_w == 32'hffffffff && !in_ready) n++;
      @(negedge clock);
    end
    check("bp_hold_cycles", 64'(n), 64'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("bp_one_result", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    in_valid = 1'b1; control = 3'd1; a_in = 32'd3; b_in = 32'd5;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clock);
    check("pre_rst_busy", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_out",   64'(out_w),     64'd0);
    check("mrst_ovf",   64'(ovf_w),     64'd0);
    check("mrst_zero",  64'(zero_w),    64'd1);
    check("mrst_ready", 64'(in_ready),  64'd1);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    check("mrst_ready_after", 64'(in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) n++;
      @(negedge clock);
    end
    check("mrst_no_result", 64'(n), 64'd0);

    // WIDTH=8 instance: SLT and the most-negative-by-minus-one multiply.
    in_valid8 = 1'b1; control8 = 3'd0; a8 = 8'hff; b8 = 8'h00; out_ready8 = 1'b1;
    @(negedge clock);
    in_valid8 = 1'b0;
    check("w8_slt_valid", 64'(out_valid8), 64'd1);
    check("w8_slt_out",   64'(out8),       64'd1);
    @(negedge clock);
    in_valid8 = 1'b1; control8 = 3'd1; a8 = 8'h80; b8 = 8'hff;
    @(negedge clock);
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 50) begin @(negedge clock); n++; end
    check("w8_mul_lat", 64'(n),    64'd9);
    check("w8_mul_out", 64'(out8), 64'h80);
    check("w8_mul_ovf", 64'(ovf8), 64'd1);
    check("w8_mul_neg", 64'(neg8), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
